// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: pipelined RV32I decode stage.
// Decodes one instruction per cycle, reads operands from an internal register
// file and registers the result into an ID/EX slot with valid/ready handshakes
// on both sides. Detects load-use hazards (inserts a bubble), honours a flush
// from execute, and stops intake after ECALL/EBREAK until reset.
//
// Optional feature: define DECODE_WB_BYPASS_EN to forward same-cycle
// write-back data into the operands captured at accept. Without it the
// captured operand is the pre-write register file value.
module decode_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int RA_W     = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic            i_flush,
    input  logic            i_wb_en,
    input  logic [RA_W-1:0] i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [RA_W-1:0] o_rs1_addr,
    output logic [RA_W-1:0] o_rs2_addr,
    output logic [RA_W-1:0] o_rd_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_funct3,
    output logic [6:0]      o_funct7,
    output logic            o_alu_input_sel,
    output logic            o_alu_sub_sel,
    output logic            o_alu_arith_sel,
    output logic            o_jump_sel,
    output logic            o_jump_type_sel,
    output logic            o_dmem_rd_en,
    output logic            o_dmem_wr_en,
    output logic            o_reg_wr_en,
    output logic [2:0]      o_reg_wr_sel,
    output logic            o_halt
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    // Write-back source encodings
    localparam logic [2:0] WB_ALU   = 3'd0;
    localparam logic [2:0] WB_MEM   = 3'd1;
    localparam logic [2:0] WB_PC4   = 3'd2;
    localparam logic [2:0] WB_IMM   = 3'd3;
    localparam logic [2:0] WB_PCIMM = 3'd4;

    // Everything the execute stage receives for one instruction
    typedef struct packed {
        logic [RA_W-1:0] rs1_addr;
        logic [RA_W-1:0] rs2_addr;
        logic [RA_W-1:0] rd_addr;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            alu_input_sel;
        logic            alu_sub_sel;
        logic            alu_arith_sel;
        logic            jump_sel;
        logic            jump_type_sel;
        logic            dmem_rd_en;
        logic            dmem_wr_en;
        logic            reg_wr_en;
        logic [2:0]      reg_wr_sel;
    } idex_t;

    opcode_e         opcode;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [RA_W-1:0] rd_addr;
    logic [31:0]     imm_i;
    logic [31:0]     imm_s;
    logic [31:0]     imm_b;
    logic [31:0]     imm_u;
    logic [31:0]     imm_j;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            wb_we;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            is_halt;
    logic            load_use;
    logic            accept;
    idex_t           dec;

    logic [XLEN-1:0] rf_q [NUM_REGS];
    idex_t           idex_d, idex_q;
    logic            valid_d, valid_q;
    logic            halted_d, halted_q;

    assign opcode   = opcode_e'(i_instr[6:0]);
    assign rd_addr  = i_instr[7 +: RA_W];
    assign rs1_addr = i_instr[15 +: RA_W];
    assign rs2_addr = i_instr[20 +: RA_W];

    assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                    i_instr[11:8], 1'b0};
    assign imm_u = {i_instr[31:12], 12'b0};
    assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                    i_instr[30:21], 1'b0};

    assign wb_we = i_wb_en && (i_wb_addr != '0);

    // Register file: cleared on reset, x0 is never written
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            // NOTE: this array is reset on purpose (architectural clear), which
            // keeps it in flops; an array without reset could map to RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we) begin
            rf_q[i_wb_addr] <= i_wb_data;
        end
    end

    // Operand read, x0 reads zero, optional same-cycle write-back forwarding
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = rf_q[rs1_addr];
`ifdef DECODE_WB_BYPASS_EN
            if (wb_we && (i_wb_addr == rs1_addr)) rs1_data = i_wb_data;
`endif
        end
        if (rs2_addr != '0) begin
            rs2_data = rf_q[rs2_addr];
`ifdef DECODE_WB_BYPASS_EN
            if (wb_we && (i_wb_addr == rs2_addr)) rs2_data = i_wb_data;
`endif
        end
    end

    // Instruction decode into the ID/EX record; unknown opcodes become NOPs
    always_comb begin
        dec          = '0;
        dec.rs1_addr = rs1_addr;
        dec.rs2_addr = rs2_addr;
        dec.rd_addr  = rd_addr;
        dec.rs1_data = rs1_data;
        dec.rs2_data = rs2_data;
        dec.funct3   = i_instr[14:12];
        dec.funct7   = i_instr[31:25];
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        is_halt      = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.imm           = XLEN'($signed(imm_u));
                dec.alu_input_sel = 1'b1;
                dec.reg_wr_en     = 1'b1;
                dec.reg_wr_sel    = WB_IMM;
            end
            OPC_AUIPC: begin
                dec.imm           = XLEN'($signed(imm_u));
                dec.alu_input_sel = 1'b1;
                dec.reg_wr_en     = 1'b1;
                dec.reg_wr_sel    = WB_PCIMM;
            end
            OPC_JAL: begin
                dec.imm           = XLEN'($signed(imm_j));
                dec.alu_input_sel = 1'b1;
                dec.jump_sel      = 1'b1;
                dec.reg_wr_en     = 1'b1;
                dec.reg_wr_sel    = WB_PC4;
            end
            OPC_JALR: begin
                dec.imm           = XLEN'($signed(imm_i));
                dec.alu_input_sel = 1'b1;
                dec.jump_sel      = 1'b1;
                dec.jump_type_sel = 1'b1;
                dec.reg_wr_en     = 1'b1;
                dec.reg_wr_sel    = WB_PC4;
                uses_rs1          = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm      = XLEN'($signed(imm_b));
                dec.jump_sel = 1'b1;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
            end
            OPC_LOAD: begin
                dec.imm           = XLEN'($signed(imm_i));
                dec.alu_input_sel = 1'b1;
                dec.dmem_rd_en    = 1'b1;
                dec.reg_wr_en     = 1'b1;
                dec.reg_wr_sel    = WB_MEM;
                uses_rs1          = 1'b1;
            end
            OPC_STORE: begin
                dec.imm           = XLEN'($signed(imm_s));
                dec.alu_input_sel = 1'b1;
                dec.dmem_wr_en    = 1'b1;
                uses_rs1          = 1'b1;
                uses_rs2          = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.imm           = XLEN'($signed(imm_i));
                dec.alu_input_sel = 1'b1;
                dec.alu_arith_sel = (i_instr[14:12] == 3'b101) && i_instr[30];
                dec.reg_wr_en     = 1'b1;
                dec.reg_wr_sel    = WB_ALU;
                uses_rs1          = 1'b1;
            end
            OPC_OP: begin
                dec.alu_sub_sel   = (i_instr[14:12] == 3'b000) && i_instr[30];
                dec.alu_arith_sel = (i_instr[14:12] == 3'b101) && i_instr[30];
                dec.reg_wr_en     = 1'b1;
                dec.reg_wr_sel    = WB_ALU;
                uses_rs1          = 1'b1;
                uses_rs2          = 1'b1;
            end
            OPC_SYSTEM: begin
                is_halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Load-use hazard: the load in ID/EX targets a register the new instruction reads
    assign load_use = valid_q && idex_q.dmem_rd_en && (idex_q.rd_addr != '0) && i_valid &&
                      ((uses_rs1 && (rs1_addr == idex_q.rd_addr)) ||
                       (uses_rs2 && (rs2_addr == idex_q.rd_addr)));

    assign o_ready = !halted_q && !load_use && (!valid_q || i_ready);
    assign accept  = i_valid && o_ready;

    // ID/EX next state: flush beats accept; a drained or bubbled slot is cleared
    always_comb begin
        idex_d   = idex_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        if (i_flush) begin
            idex_d  = '0;
            valid_d = 1'b0;
        end else if (accept) begin
            idex_d   = dec;
            valid_d  = 1'b1;
            halted_d = halted_q || is_halt;
        end else if (!valid_q || i_ready) begin
            idex_d  = '0;
            valid_d = 1'b0;
        end
    end

    // ID/EX pipeline register and sticky halt flag
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            idex_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            idex_q   <= idex_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign o_valid         = valid_q;
    assign o_halt          = halted_q;
    assign o_rs1_addr      = idex_q.rs1_addr;
    assign o_rs2_addr      = idex_q.rs2_addr;
    assign o_rd_addr       = idex_q.rd_addr;
    assign o_rs1_data      = idex_q.rs1_data;
    assign o_rs2_data      = idex_q.rs2_data;
    assign o_imm           = idex_q.imm;
    assign o_funct3        = idex_q.funct3;
    assign o_funct7        = idex_q.funct7;
    assign o_alu_input_sel = idex_q.alu_input_sel;
    assign o_alu_sub_sel   = idex_q.alu_sub_sel;
    assign o_alu_arith_sel = idex_q.alu_arith_sel;
    assign o_jump_sel      = idex_q.jump_sel;
    assign o_jump_type_sel = idex_q.jump_type_sel;
    assign o_dmem_rd_en    = idex_q.dmem_rd_en;
    assign o_dmem_wr_en    = idex_q.dmem_wr_en;
    assign o_reg_wr_en     = idex_q.reg_wr_en;
    assign o_reg_wr_sel    = idex_q.reg_wr_sel;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the decode stage (instruction
// record per slot, array register file, handshake rules).
module tb_decode_stage_pipe;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic        i_flush;
    logic        i_wb_en;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_valid;
    logic        i_ready;
    logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
    logic [31:0] o_rs1_data, o_rs2_data, o_imm;
    logic [2:0]  o_funct3;
    logic [6:0]  o_funct7;
    logic        o_alu_input_sel, o_alu_sub_sel, o_alu_arith_sel;
    logic        o_jump_sel, o_jump_type_sel;
    logic        o_dmem_rd_en, o_dmem_wr_en, o_reg_wr_en;
    logic [2:0]  o_reg_wr_sel;
    logic        o_halt;

    decode_stage_pipe dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_flush(i_flush), .i_wb_en(i_wb_en),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
        .o_rd_addr(o_rd_addr), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
        .o_imm(o_imm), .o_funct3(o_funct3), .o_funct7(o_funct7),
        .o_alu_input_sel(o_alu_input_sel), .o_alu_sub_sel(o_alu_sub_sel),
        .o_alu_arith_sel(o_alu_arith_sel), .o_jump_sel(o_jump_sel),
        .o_jump_type_sel(o_jump_type_sel), .o_dmem_rd_en(o_dmem_rd_en),
        .o_dmem_wr_en(o_dmem_wr_en), .o_reg_wr_en(o_reg_wr_en),
        .o_reg_wr_sel(o_reg_wr_sel), .o_halt(o_halt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
    localparam logic [6:0] BR = 7'h63, LOAD = 7'h03, STORE = 7'h23, OPIMM = 7'h13;
    localparam logic [6:0] OP = 7'h33, SYS = 7'h73;

    localparam logic [31:0] I_ADDI_X5 = 32'hFFD00293; // addi x5,x0,-3
    localparam logic [31:0] I_LW_X6   = 32'h0000A303; // lw   x6,0(x1)
    localparam logic [31:0] I_ADD_X7  = 32'h002303B3; // add  x7,x6,x2
    localparam logic [31:0] I_ADD_X8  = 32'h00208433; // add  x8,x1,x2
    localparam logic [31:0] I_ADD_X9  = 32'h002084B3; // add  x9,x1,x2
    localparam logic [31:0] I_BEQ     = 32'h00208463; // beq  x1,x2,+8
    localparam logic [31:0] I_SW      = 32'h0020A223; // sw   x2,4(x1)
    localparam logic [31:0] I_ADDI_X4 = 32'h00018213; // addi x4,x3,0
    localparam logic [31:0] I_ECALL   = 32'h00000073;
    localparam logic [31:0] I_EBREAK  = 32'h00100073;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [10:0] ctrl; // ain, sub, arith, jump, jalr, load, store, wr_en, wb_sel[2:0]
    } rec_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference state
    logic [31:0] m_rf [32];
    rec_t        m_rec;
    logic        m_valid;
    logic        m_halted;
    logic        last_ready;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Architectural decode of one instruction as the execute stage should see it
    function automatic rec_t model_decode(input logic [31:0] ins, input logic [31:0] d1,
                                          input logic [31:0] d2);
        rec_t r;
        logic ain, sub, ari, jmp, jty, ld, st, we;
        logic [2:0] ws;
        r = '0;
        {ain, sub, ari, jmp, jty, ld, st, we, ws} = '0;
        r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; r.rd = ins[11:7];
        r.d1 = d1; r.d2 = d2; r.f3 = ins[14:12]; r.f7 = ins[31:25];
        case (ins[6:0])
            LUI:   begin r.imm = ins[31:12] << 12; ain = 1; we = 1; ws = 3; end
            AUIPC: begin r.imm = ins[31:12] << 12; ain = 1; we = 1; ws = 4; end
            JAL:   begin
                r.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                ain = 1; jmp = 1; we = 1; ws = 2;
            end
            JALR:  begin r.imm = {{20{ins[31]}}, ins[31:20]}; ain = 1; jmp = 1; jty = 1; we = 1; ws = 2; end
            BR:    begin
                r.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                jmp = 1;
            end
            LOAD:  begin r.imm = {{20{ins[31]}}, ins[31:20]}; ain = 1; ld = 1; we = 1; ws = 1; end
            STORE: begin r.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; ain = 1; st = 1; end
            OPIMM: begin
                r.imm = {{20{ins[31]}}, ins[31:20]}; ain = 1; we = 1;
                ari = (ins[14:12] == 5) && ins[30];
            end
            OP:    begin
                we = 1;
                sub = (ins[14:12] == 0) && ins[30];
                ari = (ins[14:12] == 5) && ins[30];
            end
            default: ;
        endcase
        r.ctrl = {ain, sub, ari, jmp, jty, ld, st, we, ws};
        return r;
    endfunction

    function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
        logic [6:0] op;
        bit u1, u2;
        op = ins[6:0];
        u1 = (op == JALR) || (op == BR) || (op == LOAD) || (op == STORE) || (op == OPIMM) || (op == OP);
        u2 = (op == BR) || (op == STORE) || (op == OP);
        return (u1 && ins[19:15] == r) || (u2 && ins[24:20] == r);
    endfunction

    function automatic logic [31:0] model_operand(input logic [4:0] a, input logic we,
                                                  input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (BYPASS && we && wa == a) return wd;
        return m_rf[a];
    endfunction

    function automatic logic model_ready();
        bit stall;
        stall = m_valid && m_rec.ctrl[5] && (m_rec.rd != 0) && i_valid && reads_reg(i_instr, m_rec.rd);
        return !m_halted && !stall && (!m_valid || i_ready);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_rec = '0; m_valid = 0; m_halted = 0;
    endtask

    // Compare every DUT output with the reference state (call away from the edge)
    task automatic compare_all(input logic exp_ready);
        logic [10:0] ctrl;
        ctrl = {o_alu_input_sel, o_alu_sub_sel, o_alu_arith_sel, o_jump_sel, o_jump_type_sel,
                o_dmem_rd_en, o_dmem_wr_en, o_reg_wr_en, o_reg_wr_sel};
        check("ready", o_ready, exp_ready);
        check("valid", o_valid, m_valid);
        check("halt", o_halt, m_halted);
        check("ctrl", ctrl, m_valid ? m_rec.ctrl : 11'h0);
        if (m_valid) begin
            check("addrs", {o_rs1_addr, o_rs2_addr, o_rd_addr}, {m_rec.rs1, m_rec.rs2, m_rec.rd});
            check("rs1_data", o_rs1_data, m_rec.d1);
            check("rs2_data", o_rs2_data, m_rec.d2);
            check("imm", o_imm, m_rec.imm);
            check("funct", {o_funct7, o_funct3}, {m_rec.f7, m_rec.f3});
        end
    endtask

    // One clock cycle: drive, compare at the falling edge, advance model at the rising edge
    task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy, input logic fl,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic exp_ready, acc;
        logic [31:0] d1, d2;
        i_valid = v; i_instr = ins; i_ready = rdy; i_flush = fl;
        i_wb_en = we; i_wb_addr = wa; i_wb_data = wd;
        @(negedge i_clk);
        exp_ready = model_ready();
        compare_all(exp_ready);
        last_ready = o_ready;
        acc = v && exp_ready;
        d1 = model_operand(ins[19:15], we, wa, wd);
        d2 = model_operand(ins[24:20], we, wa, wd);
        @(posedge i_clk);
        if (fl) m_valid = 0;
        else if (acc) begin
            m_rec = model_decode(ins, d1, d2);
            m_valid = 1;
            if (ins[6:0] == SYS) m_halted = 1;
        end else if (!m_valid || rdy) m_valid = 0;
        if (we && wa != 0) m_rf[wa] = wd;
        #1;
    endtask

    task automatic run(input logic [31:0] ins, input logic rdy);
        cycle(1'b1, ins, rdy, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic apply_reset();
        i_rst = 1'b0; i_valid = 0; i_flush = 0; i_wb_en = 0; i_ready = 1;
        #2;
        model_reset();
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_halt", o_halt, 0);
        check("rst_outs", {o_imm, o_rd_addr, o_reg_wr_en, o_dmem_rd_en}, 0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0] ops [10];
        ops = '{LUI, AUIPC, JAL, JALR, BR, LOAD, STORE, OPIMM, OP, 7'h0F};
        ins = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 9)];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) ins[31:25] = 7'h00;
        return ins;
    endfunction

    initial begin
        i_rst = 1'b0; i_valid = 0; i_instr = 0; i_flush = 0; i_wb_en = 0;
        i_wb_addr = 0; i_wb_data = 0; i_ready = 1; last_ready = 0;
        apply_reset();

        // ADDI x5,x0,-3
        run(I_ADDI_X5, 1);
        check("addi_valid", o_valid, 1);
        check("addi_imm", o_imm, 32'hFFFFFFFD);
        check("addi_rd", o_rd_addr, 5);
        check("addi_alu_in", o_alu_input_sel, 1);
        check("addi_wr_en", o_reg_wr_en, 1);
        check("addi_wr_sel", o_reg_wr_sel, 0);

        // Load-use: LW x6 then ADD x7,x6,x2 -> one bubble
        run(I_LW_X6, 1);
        check("lw_rd_en", o_dmem_rd_en, 1);
        run(I_ADD_X7, 1);
        check("lu_ready_low", last_ready, 0);
        check("lu_bubble", o_valid, 0);
        run(I_ADD_X7, 1);
        check("lu_ready_high", last_ready, 1);
        check("lu_add_valid", o_valid, 1);
        check("lu_add_rd", o_rd_addr, 7);

        // Backpressure: outputs held for 3 cycles, nothing lost or duplicated
        run(I_ADD_X8, 1);
        check("hold_first", o_rd_addr, 8);
        for (int i = 0; i < 3; i++) begin
            run(I_ADD_X9, 0);
            check("hold_ready", last_ready, 0);
            check("hold_valid", o_valid, 1);
            check("hold_rd", o_rd_addr, 8);
        end
        run(I_ADD_X9, 1);
        check("hold_next_rd", o_rd_addr, 9);
        idle();
        check("hold_drain", o_valid, 0);

        // Flush while BEQ in ID/EX and SW is accepted
        run(I_BEQ, 1);
        check("beq_jump", o_jump_sel, 1);
        check("beq_imm", o_imm, 32'd8);
        cycle(1'b1, I_SW, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        check("flush_valid", o_valid, 0);
        idle();
        check("flush_no_sw", o_dmem_wr_en, 0);
        check("flush_still_empty", o_valid, 0);

        // Same-cycle write x3 and read x3
        cycle(1'b1, I_ADDI_X4, 1'b1, 1'b0, 1'b1, 5'd3, 32'h1234);
        check("bypass_rs1", o_rs1_data, BYPASS ? 32'h1234 : 32'h0);
        run(I_ADDI_X4, 1);
        check("after_wb_rs1", o_rs1_data, 32'h1234);
        // x0 stays zero
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hDEAD);
        run(32'h00000013, 1);
        check("x0_zero", o_rs1_data, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom);
        end

        // Halt: a flushed ECALL does not halt; EBREAK does and holds off intake
        idle();
        idle();
        cycle(1'b1, I_ECALL, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        check("ecall_flushed_halt", o_halt, 0);
        run(I_EBREAK, 1);
        check("ebreak_halt", o_halt, 1);
        check("ebreak_valid", o_valid, 1);
        for (int i = 0; i < 12; i++) begin
            run(I_ADDI_X5, 1);
            check("halt_ready", last_ready, 0);
        end
        check("halt_sticky", o_halt, 1);
        check("halt_drained", o_valid, 0);

        apply_reset();
        run(I_ADDI_X4, 1);
        check("post_rst_rf", o_rs1_data, 0);
        check("post_rst_valid", o_valid, 1);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
